// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end of the MIPS core.
//   fetch_state_t : fetch sequencer state encoding
//   RESET_PC_DEF  : default reset PC (MARS text segment base)
//   INSTR_BYTES   : instruction size in bytes, the PC increment
package cpu_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      EXEC = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam int          INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus.
//   imem_req    : request valid (fetch unit -> memory)
//   imem_addr   : request byte address (fetch unit -> memory)
//   imem_ready  : memory accepts the request this cycle
//   imem_rvalid : imem_rdata carries the fetched word this cycle
//   imem_rdata  : fetched instruction word
// master = fetch unit, slave = instruction memory.
interface pc_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rvalid, imem_rdata
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rvalid, imem_rdata
   );

endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer.
// Latches the selected next PC, requests the instruction at that PC and
// holds the fetched word for decode until the core lets it retire.
//   clk, rst     : clock, synchronous active-high reset
//   pc_next      : next PC from the PC-select mux (sampled on retire only)
//   stall        : hold the current instruction while in EXEC
//   imem         : instruction-memory bus (master side)
//   pc, npc      : current PC and pc + 4
//   instr        : fetched instruction word
//   instr_valid  : instr is valid for decode/execute
//   misalign_err : sticky, a misaligned pc_next was loaded
//   retired_cnt  : instructions retired since reset (wraps)
module pc_fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          CNT_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          pc_next,
   input  logic                 stall,
   pc_fetch_unit_if.master      imem,
   output logic [31:0]          pc,
   output logic [31:0]          npc,
   output logic [31:0]          instr,
   output logic                 instr_valid,
   output logic                 misalign_err,
   output logic [CNT_W-1:0]     retired_cnt
);

   fetch_state_t state, state_nxt;
   logic         capture;   // load instr from the memory response
   logic         advance;   // retire current instruction, load next PC

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT: state_nxt = REQ;
         // Zero-wait memory returns data in the accept cycle: skip WAIT.
         REQ:  if (imem.imem_ready) state_nxt = imem.imem_rvalid ? EXEC : WAIT;
         WAIT: if (imem.imem_rvalid) state_nxt = EXEC;
         EXEC: if (!stall) state_nxt = REQ;
         default: state_nxt = BOOT;
      endcase
   end

   // Output / control decode; rvalid is only honoured where a request
   // is actually in flight.
   always_comb begin
      imem.imem_req = 1'b0;
      capture       = 1'b0;
      advance       = 1'b0;
      case (state)
         REQ: begin
            imem.imem_req = 1'b1;
            capture       = imem.imem_ready & imem.imem_rvalid;
         end
         WAIT:    capture = imem.imem_rvalid;
         EXEC:    advance = ~stall;
         default: ;
      endcase
   end

   assign imem.imem_addr = pc;
   assign npc            = pc + 32'(INSTR_BYTES);

   // Datapath: PC, instruction latch, sticky error, retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         instr        <= 32'h0;
         instr_valid  <= 1'b0;
         misalign_err <= 1'b0;
         retired_cnt  <= '0;
      end else begin
         if (capture) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
         end
         if (advance) begin
            // Low bits dropped so the fetch address is always word aligned.
            pc          <= {pc_next[31:2], 2'b00};
            instr_valid <= 1'b0;
            retired_cnt <= retired_cnt + CNT_W'(1);
            if (pc_next[1:0] != 2'b00) misalign_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized self-checking bench for pc_fetch_unit, plus a second
// instance reset at the top of the address space to check PC wrap.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_PC  = 32'h0040_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
   localparam int          NCYC    = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main instance ----------------
   logic        rst, stall;
   logic [31:0] pc_next;
   logic [31:0] pc, npc, instr;
   logic        instr_valid, misalign_err;
   logic [31:0] retired_cnt;
   pc_fetch_unit_if bus();

   pc_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .pc_next(pc_next), .stall(stall), .imem(bus),
      .pc(pc), .npc(npc), .instr(instr), .instr_valid(instr_valid),
      .misalign_err(misalign_err), .retired_cnt(retired_cnt)
   );

   // ---------------- wrap instance ----------------
   logic        rst2;
   logic [31:0] pc2, npc2, instr2;
   logic        instr_valid2, misalign_err2;
   logic [31:0] retired_cnt2;
   pc_fetch_unit_if bus2();

   assign bus2.imem_ready  = 1'b1;
   assign bus2.imem_rvalid = 1'b1;
   assign bus2.imem_rdata  = 32'h2008_0005;

   pc_fetch_unit #(.RESET_PC(WRAP_PC), .CNT_W(32)) dut_wrap (
      .clk(clk), .rst(rst2), .pc_next(npc2), .stall(1'b0), .imem(bus2),
      .pc(pc2), .npc(npc2), .instr(instr2), .instr_valid(instr_valid2),
      .misalign_err(misalign_err2), .retired_cnt(retired_cnt2)
   );

   // ---------------- checking ----------------
   int vectors = 0;
   int errs    = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Memory contents: a fixed scramble of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
   endfunction

   // ---------------- reference model ----------------
   // Transaction view: either booting, waiting to issue, with a request
   // outstanding, or holding an instruction until it retires.
   logic [31:0] m_pc, m_instr, m_cnt;
   logic        m_boot, m_out, m_have, m_err;

   function automatic logic m_issuing();
      return !m_boot && !m_out && !m_have;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_pc = RST_PC; m_instr = 32'h0; m_cnt = 0;
         m_boot = 1'b1; m_out = 1'b0; m_have = 1'b0; m_err = 1'b0;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_have) begin
         if (!stall) begin
            if (pc_next[1:0] != 2'b00) m_err = 1'b1;
            m_pc   = pc_next & ~32'h3;
            m_cnt  = m_cnt + 1;
            m_have = 1'b0;
         end
      end else if (m_out) begin
         if (bus.imem_rvalid) begin
            m_instr = bus.imem_rdata; m_have = 1'b1; m_out = 1'b0;
         end
      end else if (bus.imem_ready) begin
         if (bus.imem_rvalid) begin
            m_instr = bus.imem_rdata; m_have = 1'b1;
         end else begin
            m_out = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      chk("pc",           pc,             m_pc);
      chk("npc",          npc,            m_pc + 32'd4);
      chk("imem_addr",    bus.imem_addr,  m_pc);
      chk("imem_req",     bus.imem_req,   m_issuing());
      chk("instr_valid",  instr_valid,    m_have);
      chk("instr",        instr,          m_instr);
      chk("misalign_err", misalign_err,   m_err);
      chk("retired_cnt",  retired_cnt,    m_cnt);
   endtask

   // Memory behaviour chosen from the model's view of the bus
   task automatic drive_cycle(input logic force_rst);
      logic real_rsp;
      rst   = force_rst || ($urandom_range(0, 63) == 0);
      stall = ($urandom_range(0, 9) < 3);
      pc_next = $urandom & 32'h00FF_FFFC;
      if ($urandom_range(0, 7) == 0) pc_next[1:0] = 2'($urandom_range(1, 3));
      bus.imem_ready = 1'($urandom_range(0, 1));
      if (m_issuing())
         bus.imem_rvalid = bus.imem_ready ? 1'($urandom_range(0, 1))
                                          : ($urandom_range(0, 3) == 0);
      else if (m_out)
         bus.imem_rvalid = ($urandom_range(0, 2) == 0);
      else
         bus.imem_rvalid = ($urandom_range(0, 3) == 0);  // spurious, must be ignored
      real_rsp = !rst && ((m_issuing() && bus.imem_ready && bus.imem_rvalid) ||
                          (m_out && bus.imem_rvalid));
      bus.imem_rdata = real_rsp ? mem_word(m_pc) : $urandom;
   endtask

   initial begin
      rst = 1'b1; rst2 = 1'b1; stall = 1'b0; pc_next = 32'h0;
      bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;

      // Wrap instance: top-of-memory PC rolls over to 0
      @(negedge clk);
      chk("wrap_rst_pc",  pc2,  WRAP_PC);
      chk("wrap_npc",     npc2, 32'h0);
      chk("wrap_rst_req", bus2.imem_req, 1'b0);
      rst2 = 1'b0;
      @(negedge clk);                      // REQ
      chk("wrap_req",     bus2.imem_req, 1'b1);
      @(negedge clk);                      // EXEC
      chk("wrap_instr",   instr2, 32'h2008_0005);
      chk("wrap_valid",   instr_valid2, 1'b1);
      @(negedge clk);                      // REQ at pc 0
      chk("wrap_pc",      pc2, 32'h0);
      chk("wrap_cnt",     retired_cnt2, 32'd1);
      chk("wrap_err",     misalign_err2, 1'b0);

      // Main instance: randomized run against the model
      for (int i = 0; i < NCYC; i++) begin
         drive_cycle(i < 2);
         model_step();
         @(negedge clk);
         check_all();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
